// File: rtl/crc32_pkg.sv
// ----------------------------------------------------------------------------
// crc32_pkg
// Shared definitions for the CRC-32 frame checker and any CRC generator that
// pairs with it.
//   CRC32_POLY  - generator polynomial 0x04C11DB7 (MSB-first, non-reflected)
//   CRC32_INIT  - seed value loaded at the start of every frame
//   crc_state_t - checker FSM state encoding (IDLE, DATA, CHECK)
//   crc8x4()    - folds one 32-bit word into a running CRC as four bytes,
//                 most significant byte first, with no reflection and no
//                 final XOR
// ----------------------------------------------------------------------------
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } crc_state_t;

    // One word = four byte steps, byte [31:24] first. Each byte is XORed into
    // the top of the register and then shifted out bit by bit.
    function automatic logic [31:0] crc8x4(input logic [31:0] crc,
                                           input logic [31:0] word);
        logic [31:0] c;
        c = crc;
        for (int b = 3; b >= 0; b--) begin
            c = c ^ {word[b*8 +: 8], 24'h000000};
            for (int i = 0; i < 8; i++) begin
                c = c[31] ? ({c[30:0], 1'b0} ^ CRC32_POLY) : {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_checker_if.sv
// ----------------------------------------------------------------------------
// crc32_checker_if
// Beat stream into the CRC-32 checker and its per-frame result outputs.
//   in_valid/in_ready - handshake; a beat moves when both are high
//   in_sof/in_eof     - first word / last (CRC) word of a frame
//   in_data           - payload or received CRC word
//   out_done          - one-cycle pulse at the end of a frame check
//   out_ok/out_err_crc- CRC comparison result, meaningful with out_done
//   out_err_proto     - one-cycle pulse on a framing or length violation
//   out_crc/out_words - computed CRC and payload length of the last frame
// Modports: master drives beats (source side), slave is the checker.
// ----------------------------------------------------------------------------
interface crc32_checker_if;

    logic        in_valid;
    logic        in_sof;
    logic        in_eof;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_done;
    logic        out_ok;
    logic        out_err_crc;
    logic        out_err_proto;
    logic [31:0] out_crc;
    logic [15:0] out_words;

    modport master (
        output in_valid, in_sof, in_eof, in_data,
        input  in_ready, out_done, out_ok, out_err_crc, out_err_proto,
               out_crc, out_words
    );

    modport slave (
        input  in_valid, in_sof, in_eof, in_data,
        output in_ready, out_done, out_ok, out_err_crc, out_err_proto,
               out_crc, out_words
    );

endinterface

// File: rtl/crc32_word_comb.sv
// ----------------------------------------------------------------------------
// crc32_word_comb
// Purely combinational single-word CRC-32 step, shared by checker and
// generator datapaths.
//   crc_in  - running CRC before this word
//   data    - 32-bit word, byte [31:24] processed first
//   crc_out - running CRC after this word
// ----------------------------------------------------------------------------
module crc32_word_comb
    import crc32_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    output logic [31:0] crc_out
);

    assign crc_out = crc8x4(crc_in, data);

endmodule

// File: rtl/crc32_checker.sv
// ----------------------------------------------------------------------------
// crc32_checker
// Receives framed 32-bit words, computes a CRC-32 over the payload and
// compares it with the trailing CRC word carried on the eof beat.
//   clk - single clock, rising edge
//   rst - asynchronous, active-high reset
//   bus - crc32_checker_if.slave (beat input, result outputs)
// Parameter MAX_WORDS bounds the payload length (CRC word excluded); a frame
// that tries to exceed it is dropped with an out_err_proto pulse.
// The eof beat is accepted on one edge and its result (out_done plus
// out_ok/out_err_crc, out_crc, out_words) is visible right after that edge,
// during the single CHECK cycle in which in_ready is low.
// ----------------------------------------------------------------------------
module crc32_checker
    import crc32_pkg::*;
#(
    parameter int MAX_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    crc32_checker_if.slave  bus
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

    crc_state_t  state_r;
    crc_state_t  state_n;
    logic [31:0] crc_r;
    logic [31:0] crc_n;
    logic [15:0] count_r;
    logic [15:0] count_n;

    logic        done_r;
    logic        done_n;
    logic        ok_r;
    logic        ok_n;
    logic        err_crc_r;
    logic        err_crc_n;
    logic        err_proto_r;
    logic        err_proto_n;
    logic [31:0] res_crc_r;
    logic [31:0] res_crc_n;
    logic [15:0] res_words_r;
    logic [15:0] res_words_n;

    logic        in_ready_s;
    logic        beat_s;
    logic        restart_s;
    logic [31:0] frame_crc_s;
    logic [15:0] frame_cnt_s;
    logic [31:0] crc_step_s;
    logic        match_s;

    // Ready everywhere except the CHECK cycle, and held low during reset.
    assign in_ready_s = !rst && (state_r != ST_CHECK);
    assign beat_s     = bus.in_valid && in_ready_s;

    // A sof beat while in DATA abandons the frame in progress.
    assign restart_s  = (state_r == ST_DATA) && bus.in_sof;

    // An sof beat always starts from the seed, whatever the running state is,
    // so the same datapath serves a fresh frame and a restart.
    assign frame_crc_s = bus.in_sof ? CRC32_INIT : crc_r;
    assign frame_cnt_s = bus.in_sof ? 16'd0 : count_r;
    assign match_s     = (bus.in_data == frame_crc_s);

    crc32_word_comb u_word (
        .crc_in  (frame_crc_s),
        .data    (bus.in_data),
        .crc_out (crc_step_s)
    );

    // Next-state, datapath and result computation for one accepted beat.
    always_comb begin
        state_n     = state_r;
        crc_n       = crc_r;
        count_n     = count_r;
        done_n      = 1'b0;
        ok_n        = 1'b0;
        err_crc_n   = 1'b0;
        err_proto_n = 1'b0;
        res_crc_n   = res_crc_r;
        res_words_n = res_words_r;
        case (state_r)
            ST_IDLE, ST_DATA: begin
                if (beat_s) begin
                    if (!bus.in_sof && (state_r == ST_IDLE)) begin
                        // Stray beat outside a frame: drop it.
                        err_proto_n = 1'b1;
                    end else if (bus.in_eof) begin
                        // CRC word: compared, never folded into the CRC.
                        err_proto_n = restart_s;
                        state_n     = ST_CHECK;
                        done_n      = 1'b1;
                        ok_n        = match_s;
                        err_crc_n   = !match_s;
                        res_crc_n   = frame_crc_s;
                        res_words_n = frame_cnt_s;
                        crc_n       = CRC32_INIT;
                        count_n     = 16'd0;
                    end else if (!bus.in_sof && (count_r == MAX_CNT)) begin
                        // Payload would exceed MAX_WORDS: drop the frame.
                        err_proto_n = 1'b1;
                        state_n     = ST_IDLE;
                        crc_n       = CRC32_INIT;
                        count_n     = 16'd0;
                    end else begin
                        err_proto_n = restart_s;
                        state_n     = ST_DATA;
                        crc_n       = crc_step_s;
                        count_n     = frame_cnt_s + 16'd1;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            ST_CHECK: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                crc_n   = CRC32_INIT;
                count_n = 16'd0;
            end
        endcase
    end

    // State, running CRC/count and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            crc_r       <= CRC32_INIT;
            count_r     <= 16'd0;
            done_r      <= 1'b0;
            ok_r        <= 1'b0;
            err_crc_r   <= 1'b0;
            err_proto_r <= 1'b0;
            res_crc_r   <= 32'd0;
            res_words_r <= 16'd0;
        end else begin
            state_r     <= state_n;
            crc_r       <= crc_n;
            count_r     <= count_n;
            done_r      <= done_n;
            ok_r        <= ok_n;
            err_crc_r   <= err_crc_n;
            err_proto_r <= err_proto_n;
            res_crc_r   <= res_crc_n;
            res_words_r <= res_words_n;
        end
    end

    assign bus.in_ready      = in_ready_s;
    assign bus.out_done      = done_r;
    assign bus.out_ok        = ok_r;
    assign bus.out_err_crc   = err_crc_r;
    assign bus.out_err_proto = err_proto_r;
    assign bus.out_crc       = res_crc_r;
    assign bus.out_words     = res_words_r;

endmodule

// File: tb/tb_crc32_checker.sv
// ----------------------------------------------------------------------------
// tb_crc32_checker
// Directed frames into crc32_checker (MAX_WORDS=4). Each issued beat that
// should produce a response pushes the expected event (done or proto pulse,
// with the cycle it must appear in) into a queue; a monitor on the falling
// edge pops and compares whenever the DUT pulses out_done or out_err_proto.
// ----------------------------------------------------------------------------
module tb_crc32_checker;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef struct {
        bit          is_done;
        bit          ok;
        logic [31:0] crc;
        logic [15:0] words;
        int unsigned at;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int          n_checks;
    int          n_pass;
    exp_t        exp_q[$];

    crc32_checker_if bus ();

    crc32_checker #(.MAX_WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit cond, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (cond) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Bit-serial reference: one data bit per step, MSB of each byte first.
    function automatic logic [31:0] gold(input logic [31:0] w[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (w[k]) begin
            for (int b = 31; b >= 0; b--) begin
                fb = c[31] ^ w[k][b];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ POLY;
            end
        end
        return c;
    endfunction

    // Drive one beat; returns the cycle stamp in which its response is due.
    task automatic send(input bit sof, input bit eof, input logic [31:0] d,
                        input bit gap, output int unsigned due);
        int n;
        if (gap) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_eof   = eof;
        bus.in_data  = d;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check(1'b0, "ready_timeout", 32'd0, 32'd1);
        due = cyc + 1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic push_done(input int unsigned due, input bit ok,
                             input logic [31:0] crc, input logic [15:0] words);
        exp_t e;
        e.is_done = 1'b1;
        e.ok      = ok;
        e.crc     = crc;
        e.words   = words;
        e.at      = due;
        exp_q.push_back(e);
    endtask

    task automatic push_proto(input int unsigned due);
        exp_t e;
        e.is_done = 1'b0;
        e.ok      = 1'b0;
        e.crc     = 32'd0;
        e.words   = 16'd0;
        e.at      = due;
        exp_q.push_back(e);
    endtask

    // Send a whole frame (payload words then the given CRC word).
    task automatic frame(input logic [31:0] w[$], input logic [31:0] crc_word,
                         input bit gap, output int unsigned due);
        int unsigned d;
        foreach (w[k]) send(k == 0, 1'b0, w[k], gap, d);
        send(w.size() == 0, 1'b1, crc_word, gap, due);
    endtask

    // Monitor: compare every result pulse against the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.out_done) begin
                check({bus.out_ok, bus.out_err_crc} == 2'b00, "flags_idle",
                      {30'd0, bus.out_ok, bus.out_err_crc}, 32'd0);
            end
            if (bus.out_done || bus.out_err_proto) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_pulse",
                          {30'd0, bus.out_done, bus.out_err_proto}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(cyc == e.at, "latency", cyc, e.at);
                    check({bus.out_done, bus.out_err_proto} == {e.is_done, !e.is_done},
                          "pulse_kind", {30'd0, bus.out_done, bus.out_err_proto},
                          {30'd0, e.is_done, !e.is_done});
                    if (e.is_done) begin
                        check(bus.out_ok == e.ok, "out_ok", {31'd0, bus.out_ok}, {31'd0, e.ok});
                        check(bus.out_err_crc == !e.ok, "out_err_crc",
                              {31'd0, bus.out_err_crc}, {31'd0, !e.ok});
                        check(bus.out_crc == e.crc, "out_crc", bus.out_crc, e.crc);
                        check(bus.out_words == e.words, "out_words",
                              {16'd0, bus.out_words}, {16'd0, e.words});
                        check(bus.in_ready == 1'b0, "ready_in_check",
                              {31'd0, bus.in_ready}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0]  pa[$];
        logic [31:0]  pb[$];
        logic [31:0]  g;
        int unsigned  due;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eof   = 1'b0;
        bus.in_data  = 32'd0;
        n_checks     = 0;
        n_pass       = 0;

        // Reset state.
        repeat (3) @(negedge clk);
        check(bus.in_ready == 1'b0, "rst_ready", {31'd0, bus.in_ready}, 32'd0);
        check({bus.out_done, bus.out_ok, bus.out_err_crc, bus.out_err_proto} == 4'd0,
              "rst_flags", {28'd0, bus.out_done, bus.out_ok, bus.out_err_crc,
              bus.out_err_proto}, 32'd0);
        check(bus.out_crc == 32'd0, "rst_crc", bus.out_crc, 32'd0);
        check(bus.out_words == 16'd0, "rst_words", {16'd0, bus.out_words}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check(bus.in_ready == 1'b1, "idle_ready", {31'd0, bus.in_ready}, 32'd1);

        // CRC-only frames: good then bad.
        send(1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, due);
        push_done(due, 1'b1, 32'hFFFFFFFF, 16'd0);
        send(1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, due);
        push_done(due, 1'b0, 32'hFFFFFFFF, 16'd0);

        // Three-word frame with valid gaps, good CRC.
        pa = '{32'h01020304, 32'hDEADBEEF, 32'h00000000};
        g  = gold(pa);
        frame(pa, g, 1'b1, due);
        push_done(due, 1'b1, g, 16'd3);

        // Same frame with bit 0 of word 2 flipped, original CRC word.
        pb = '{32'h01020304, 32'hDEADBEEE, 32'h00000000};
        frame(pb, g, 1'b1, due);
        push_done(due, 1'b0, gold(pb), 16'd3);

        // sof mid-frame restarts, then a stray beat in IDLE.
        send(1'b1, 1'b0, 32'h11111111, 1'b0, due);
        send(1'b0, 1'b0, 32'h22222222, 1'b0, due);
        send(1'b1, 1'b0, 32'hCAFEF00D, 1'b0, due);
        push_proto(due);
        send(1'b0, 1'b0, 32'h12345678, 1'b0, due);
        pa = '{32'hCAFEF00D, 32'h12345678};
        g  = gold(pa);
        send(1'b0, 1'b1, g, 1'b0, due);
        push_done(due, 1'b1, g, 16'd2);
        send(1'b0, 1'b0, 32'hAAAA5555, 1'b0, due);
        push_proto(due);

        // Exactly MAX_WORDS payload words is legal.
        pa = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
        g  = gold(pa);
        frame(pa, g, 1'b0, due);
        push_done(due, 1'b1, g, 16'd4);

        // Fifth payload word overflows; the following eof beat lands in IDLE.
        foreach (pa[k]) send(k == 0, 1'b0, pa[k], 1'b0, due);
        send(1'b0, 1'b0, 32'h00000005, 1'b0, due);
        push_proto(due);
        send(1'b0, 1'b1, g, 1'b0, due);
        push_proto(due);

        // Reset during DATA discards the frame silently.
        send(1'b1, 1'b0, 32'h0BADF00D, 1'b0, due);
        send(1'b0, 1'b0, 32'h0BADF00D, 1'b0, due);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pa = '{32'h00000001};
        g  = gold(pa);
        frame(pa, g, 1'b0, due);
        push_done(due, 1'b1, g, 16'd1);

        repeat (5) @(negedge clk);
        check(exp_q.size() == 0, "missing_pulses", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/crc32_checker.md
CRC32_CHECKER -- requirements
Module: crc32_checker

Interface
REQ-001 The parameter MAX_WORDS SHALL default to 1024 and SHALL set the maximum number of payload words per frame, excluding the CRC word.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  the current beat carries a word.
REQ-005 in_sof  input  1  the beat is the first word of a frame.
REQ-006 in_eof  input  1  the beat is the last word of a frame, which is the received CRC word.
REQ-007 in_data  input  32  the payload or CRC word.
REQ-008 in_ready  output  1  the checker accepts a beat; a beat is accepted when in_valid and in_ready are both high.
REQ-009 out_done  output  1  one-cycle pulse marking the end of a frame check.
REQ-010 out_ok  output  1  the received CRC matches the computed CRC; valid while out_done is high.
REQ-011 out_err_crc  output  1  the received CRC does not match; valid while out_done is high.
REQ-012 out_err_proto  output  1  one-cycle pulse on a framing or length violation.
REQ-013 out_crc  output  32  the computed CRC of the last completed frame's payload.
REQ-014 out_words  output  16  the payload word count of the last completed frame.

Function
REQ-015 The CRC SHALL use polynomial 0x04C11DB7, MSB-first bit order, initial value 0xFFFFFFFF, no reflection and no final XOR.
REQ-016 The CRC SHALL process each payload word as four bytes in the order in_data[31:24], [23:16], [15:8], [7:0], all within one cycle.
REQ-017 The states SHALL be IDLE, DATA and CHECK.
REQ-018 IDLE: an accepted beat with sof=1 and eof=0 SHALL load the running CRC with crc8x4(0xFFFFFFFF, in_data), set the count to 1, and move to DATA.
REQ-019 IDLE: an accepted beat with sof=1 and eof=1 (CRC-only frame) SHALL compare in_data with 0xFFFFFFFF, set the count to 0, and move to CHECK.
REQ-020 IDLE: an accepted beat with sof=0 SHALL be dropped and SHALL pulse out_err_proto in the next cycle; the state stays IDLE.
REQ-021 DATA: an accepted beat with sof=0 and eof=0 SHALL update the running CRC and increment the count.
REQ-022 DATA: an accepted beat with eof=1 SHALL compare in_data against the running CRC (the word is not folded in) and move to CHECK.
REQ-023 DATA: an accepted beat with sof=1 SHALL abort the current frame, pulse out_err_proto, and restart as in REQ-018 or REQ-019 using that beat.
REQ-024 DATA: when the count equals MAX_WORDS and a further non-eof beat is accepted, the beat SHALL be dropped, out_err_proto SHALL pulse, and the state SHALL return to IDLE.
REQ-025 CHECK lasts exactly one cycle, with in_ready=0; it SHALL then return to IDLE.
REQ-026 In CHECK the outputs SHALL be out_done=1, with out_ok and out_err_crc registered from the comparison, and out_crc and out_words updated.
REQ-027 Latency from the accepted eof beat to out_done SHALL be exactly one cycle.
REQ-028 Exactly one of out_ok and out_err_crc SHALL be high while out_done is high; both SHALL be 0 otherwise.
REQ-029 in_ready SHALL be 1 in IDLE and DATA.
REQ-030 in_valid=0 cycles SHALL hold all state, in any state.
REQ-031 The count SHALL never wrap; REQ-024 bounds it.

Reset
REQ-032 Reset SHALL force IDLE, running CRC 0xFFFFFFFF, count 0, in_ready=0 while rst is high, and out_done, out_ok, out_err_crc, out_err_proto, out_crc and out_words all 0.
REQ-033 Reset mid-frame SHALL discard the frame with no out_done and no error pulse; the first accepted beat after release SHALL be treated as arriving in IDLE.

Structure
REQ-034 A shared package crc32_pkg SHALL hold CRC32_POLY, CRC32_INIT, the function crc8x4 (32-bit state, 32-bit word) and the state enum typedef.
REQ-035 The per-beat CRC update SHALL be a combinational sub-module crc32_word_comb (inputs crc_in and data; output crc_out), reused by the generator side.

Verification
REQ-036 The bench SHALL drive a single beat with sof=1, eof=1, data=0xFFFFFFFF and require, one cycle later, out_done=1, out_ok=1, out_words=0 and out_crc=0xFFFFFFFF.
REQ-037 The bench SHALL drive the same frame with data=0xFFFFFFFE and require out_done=1, out_err_crc=1 and out_ok=0.
REQ-038 The bench SHALL drive payload 0x01020304, 0xDEADBEEF, 0x00000000 followed by the golden-model CRC, with random in_valid gaps, and require out_ok=1, out_words=3 and out_crc equal to the golden value.
REQ-039 The bench SHALL repeat REQ-038 with bit 0 of the second word flipped and require out_err_crc=1.
REQ-040 The bench SHALL drive sof mid-frame, then a stray non-sof beat in IDLE, and require one out_err_proto pulse for each and a correct check of the restarted frame.
REQ-041 With MAX_WORDS=4, the bench SHALL drive 5 payload words and require out_err_proto=1 on the 5th, no out_done, and return to IDLE; it SHALL also assert rst during DATA and require no out_done.
